fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Small instruction buffer between the instruction ROM and the decode stage of the MIPS datapath.
- Accepts {PC, instruction} pairs from the fetch side with a valid/ready handshake and presents them in order to decode.
- Decouples fetch from decode stalls and discards all buffered instructions on a branch/jump flush.
- First-word-fall-through FIFO; an empty or flushed queue presents a NOP (0x00000000) to decode.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all entries (branch/jump redirect).
- in_valid  input  1  fetch side presents a valid pair.
- in_pc  input  32  PC of the incoming instruction.
- in_inst  input  32  instruction word from the instruction ROM.
- in_ready  output  1  queue can accept a push this cycle.
- out_valid  output  1  head entry is valid.
- out_pc  output  32  PC of the head entry.
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
- out_inst  output  32  instruction at the head.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  ADDR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- State: DEPTH x 64-bit storage, wr_ptr and rd_ptr (ADDR_W bits each), count. All state updates on the rising edge of clk.
- Reset: when rst=1 at an edge, wr_ptr, rd_ptr and count become 0.
  - After reset: out_valid=0, in_ready=1, count=0, out_pc=0, out_pc_plus4=4, out_inst=0.
  - Storage contents are not reset.
  - rst has priority over flush, push and pop.
- in_ready = (count != DEPTH). It is combinational from count only. There is no same-cycle pop-enables-push bypass, so a full queue refuses a push even when a pop occurs in the same cycle.
- out_valid = (count != 0).
- Head outputs when out_valid=1: out_pc, out_inst and out_pc_plus4 come combinationally from the entry at rd_ptr.
- Head outputs when out_valid=0: out_pc=0, out_inst=0 (NOP), out_pc_plus4=4.
- push = in_valid & in_ready & ~flush.
  - Writes {in_pc, in_inst} at wr_ptr.
  - wr_ptr increments, wrapping from DEPTH-1 to 0.
- pop = out_valid & out_ready & ~flush.
  - rd_ptr increments, wrapping from DEPTH-1 to 0.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push and pop together.
- Latency: a push into an empty queue appears on out_valid/out_* in the next cycle. There is no combinational in-to-out path.
- Ordering: strict FIFO. Entries never duplicate and never drop, except on flush or reset.
- flush=1 (with rst=0):
  - At the edge, wr_ptr, rd_ptr and count become 0.
  - Any push in that cycle is discarded.
  - Any out_ready in that cycle does not count as a pop.
  - The next cycle shows out_valid=0 and in_ready=1.
  - During the flush cycle itself, outputs still reflect the pre-flush state.
- Boundaries:
  - Full (count=DEPTH) with in_valid=1: in_ready=0, nothing written, contents unchanged.
  - Empty with out_ready=1: no pointer change, and count never underflows.
  - Wrap-around: pointers wrap modulo DEPTH with no gap or reordering.
  - out_pc_plus4 from 0xFFFFFFFC is 0x00000000.
- Reset asserted mid-operation behaves exactly like reset from power-up. A push or pop in the reset cycle is ignored.

Test Plan:
- Reset, then idle, then push one entry: rst=1 for 2 cycles, then push {pc=0x0, inst=0x20080005}.
  - During and after reset: out_valid=0, out_inst=0, count=0, in_ready=1.
  - One cycle after the push: out_valid=1, out_pc=0, out_pc_plus4=4, out_inst=0x20080005.
- Fill and backpressure:
  - Push PCs 0, 4, 8, 12 with out_ready=0 → count=4, in_ready=0.
  - Then push PC 16 → refused, count stays 4.
  - Drain with out_ready=1 → out_pc sequence 0, 4, 8, 12, then out_valid=0.
- Simultaneous push and pop at count=2 → count stays 2 and order is preserved.
- At count=4 with in_valid=1 and out_ready=1 → only the pop occurs; count goes to 3.
- Wrap-around: stream 10 entries (PCs 0..36) with out_ready toggling 1,0,1,0 → output PC sequence is exactly 0..36 in steps of 4, with no duplicates or skips.
- Flush:
  - With count=3, assert flush together with in_valid=1 (pc=0x40) → next cycle count=0, out_valid=0, out_inst=0.
  - Next push of pc=0x80 → appears at the head one cycle later.
- Reset mid-stream: at count=2, assert rst together with in_valid and out_ready → next cycle count=0, out_valid=0; pointers restart and the next push is output first.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through instruction buffer between the
// instruction ROM (fetch side) and the decode stage.
//
// Holds up to DEPTH {pc, instruction} pairs in order. Fetch pushes with a
// valid/ready handshake, and decode pops the head with out_ready. A flush
// (branch/jump redirect) discards every buffered entry. An empty queue
// presents a NOP (all-zero instruction) at pc 0 to decode.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset (priority over everything)
//   flush        discard all entries; ignores same-cycle push/pop
//   in_valid     fetch presents a pair
//   in_pc        pc of the incoming instruction
//   in_inst      incoming instruction word
//   in_ready     queue can accept a push (count != DEPTH)
//   out_valid    head entry valid (count != 0)
//   out_pc       pc of the head entry (0 when empty)
//   out_pc_plus4 out_pc + 4, modulo 2^32
//   out_inst     head instruction (NOP when empty)
//   out_ready    decode consumes the head this cycle
//   count        occupied entries, 0..DEPTH

module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    output logic              in_ready,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc_plus4,
    output logic [31:0]       out_inst,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              push;
    logic              pop;
    logic [63:0]       head;

    // No pop-enables-push bypass: in_ready depends on count only.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Empty queue shows a NOP at pc 0 so decode sees harmless data.
    assign head         = out_valid ? mem[rd_ptr] : 64'd0;
    assign out_pc       = head[63:32];
    assign out_inst     = head[31:0];
    assign out_pc_plus4 = out_pc + 32'd4;

    // Storage is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= {in_pc, in_inst};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [2:0]  count;

    int total;
    int bad;

    fetch_queue #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_pc_plus4(out_pc_plus4),
        .out_inst    (out_inst),
        .out_ready   (out_ready),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h1000_0000 ^ pc;
    endfunction

    task automatic push_one(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst_of(pc);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_inst !== 32'd0 || count !== 3'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_during: valid=%b inst=%h count=%0d in_ready=%b want 0/0/0/1",
                     out_valid, out_inst, count, in_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_pc_plus4 !== 32'd4 ||
            out_inst !== 32'd0 || count !== 3'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_after: valid=%b pc=%h pc4=%h inst=%h count=%0d rdy=%b",
                     out_valid, out_pc, out_pc_plus4, out_inst, count, in_ready);
        end
        in_valid = 1'b1;
        in_pc    = 32'h0;
        in_inst  = 32'h2008_0005;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_pc_plus4 !== 32'd4 ||
            out_inst !== 32'h2008_0005 || count !== 3'd1) begin
            bad++;
            $display("FAIL first_push: valid=%b pc=%h pc4=%h inst=%h count=%0d want 1/0/4/20080005/1",
                     out_valid, out_pc, out_pc_plus4, out_inst, count);
        end
        pop_one();
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_pop: count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_fill_backpressure();
        logic [31:0] exp_pc;
        for (int i = 0; i < 4; i++) push_one(32'(i * 4));
        total++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill: count=%0d in_ready=%b want 4/0", count, in_ready);
        end
        push_one(32'd16);
        total++;
        if (count !== 3'd4 || out_pc !== 32'd0) begin
            bad++;
            $display("FAIL full_refuse: count=%0d head=%h want 4/0", count, out_pc);
        end
        // full queue with push and pop together: only the pop happens
        in_valid  = 1'b1;
        in_pc     = 32'd16;
        in_inst   = inst_of(32'd16);
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        total++;
        if (count !== 3'd3 || out_pc !== 32'd4) begin
            bad++;
            $display("FAIL full_push_pop: count=%0d head=%h want 3/4", count, out_pc);
        end
        for (int i = 1; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            total++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== inst_of(exp_pc)) begin
                bad++;
                $display("FAIL drain_%0d: valid=%b pc=%h inst=%h want pc=%h", i, out_valid,
                         out_pc, out_inst, exp_pc);
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_inst !== 32'd0) begin
            bad++;
            $display("FAIL drain_empty: valid=%b count=%0d inst=%h want 0/0/0", out_valid, count, out_inst);
        end
    endtask

    task automatic test_push_pop_same_cycle();
        push_one(32'h50);
        push_one(32'h54);
        in_valid  = 1'b1;
        in_pc     = 32'h58;
        in_inst   = inst_of(32'h58);
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        total++;
        if (count !== 3'd2 || out_pc !== 32'h54) begin
            bad++;
            $display("FAIL push_pop_count: count=%0d head=%h want 2/54", count, out_pc);
        end
        tick();
        total++;
        if (count !== 3'd1 || out_pc !== 32'h58 || out_inst !== inst_of(32'h58)) begin
            bad++;
            $display("FAIL push_pop_order: count=%0d head=%h want 1/58", count, out_pc);
        end
        tick();
        out_ready = 1'b0;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL push_pop_drain: count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_wrap();
        int next_in;
        int exp_idx;
        int cyc;
        next_in = 0;
        exp_idx = 0;
        cyc     = 0;
        while (exp_idx < 10 && cyc < 100) begin
            in_valid  = (next_in < 10);
            in_pc     = 32'(next_in * 4);
            in_inst   = inst_of(32'(next_in * 4));
            out_ready = (cyc % 2 == 0);
            #0;
            if (out_valid && out_ready) begin
                total++;
                if (out_pc !== 32'(exp_idx * 4) || out_inst !== inst_of(32'(exp_idx * 4)) ||
                    out_pc_plus4 !== 32'(exp_idx * 4 + 4)) begin
                    bad++;
                    $display("FAIL wrap_%0d: pc=%h inst=%h pc4=%h want pc=%h", exp_idx,
                             out_pc, out_inst, out_pc_plus4, 32'(exp_idx * 4));
                end
                exp_idx++;
            end
            if (in_valid && in_ready) next_in++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (exp_idx != 10 || count !== 3'd0) begin
            bad++;
            $display("FAIL wrap_done: popped=%0d count=%0d want 10/0", exp_idx, count);
        end
    endtask

    task automatic test_flush();
        push_one(32'h100);
        push_one(32'h104);
        push_one(32'h108);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h40;
        in_inst   = inst_of(32'h40);
        out_ready = 1'b1;
        total++;
        if (count !== 3'd3 || out_valid !== 1'b1 || out_pc !== 32'h100) begin
            bad++;
            $display("FAIL flush_pre: count=%0d valid=%b head=%h want 3/1/100", count, out_valid, out_pc);
        end
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_inst !== 32'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_post: count=%0d valid=%b inst=%h rdy=%b want 0/0/0/1",
                     count, out_valid, out_inst, in_ready);
        end
        push_one(32'h80);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h80 || count !== 3'd1) begin
            bad++;
            $display("FAIL flush_repush: valid=%b head=%h count=%0d want 1/80/1", out_valid, out_pc, count);
        end
        pop_one();
    endtask

    task automatic test_empty_pop_and_pc_wrap();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL empty_pop: count=%0d valid=%b rdy=%b want 0/0/1", count, out_valid, in_ready);
        end
        push_one(32'hFFFF_FFFC);
        total++;
        if (out_pc !== 32'hFFFF_FFFC || out_pc_plus4 !== 32'd0 || count !== 3'd1) begin
            bad++;
            $display("FAIL pc4_wrap: pc=%h pc4=%h count=%0d want fffffffc/0/1", out_pc, out_pc_plus4, count);
        end
        pop_one();
    endtask

    task automatic test_reset_mid();
        push_one(32'h200);
        push_one(32'h204);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h208;
        in_inst   = inst_of(32'h208);
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_pc_plus4 !== 32'd4) begin
            bad++;
            $display("FAIL reset_mid: count=%0d valid=%b pc4=%h want 0/0/4", count, out_valid, out_pc_plus4);
        end
        push_one(32'h300);
        push_one(32'h304);
        total++;
        if (out_pc !== 32'h300 || count !== 3'd2) begin
            bad++;
            $display("FAIL reset_mid_push: head=%h count=%0d want 300/2", out_pc, count);
        end
        pop_one();
        total++;
        if (out_pc !== 32'h304 || count !== 3'd1) begin
            bad++;
            $display("FAIL reset_mid_order: head=%h count=%0d want 304/1", out_pc, count);
        end
        pop_one();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'd0;
        in_inst   = 32'd0;
        out_ready = 1'b0;
        test_reset();
        test_fill_backpressure();
        test_push_pop_same_cycle();
        test_wrap();
        test_flush();
        test_empty_pop_and_pc_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
